// File: rtl/uart_message_printer_pkg.sv
// Shared types and constants for the binary-digit collector / message printer.
// Also holds the nibble-to-ASCII helper used to build the hex part of the message.
package uart_message_printer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    PRINT   = 1'b1
  } state_t;

  localparam int unsigned MSG_LEN = 15;
  localparam logic [7:0]  ASCII_0 = 8'h30;
  localparam logic [7:0]  ASCII_1 = 8'h31;
  localparam logic [7:0]  CR      = 8'h0D;
  localparam logic [7:0]  LF      = 8'h0A;

  // Uppercase hex digit: 0-9 map onto '0'.., 10-15 onto 'A'.. (8'h37 + 10 = 'A').
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (ASCII_0 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/uart_message_printer_rom.sv
// Combinational message table: "Got byte 0xHH\r\n" indexed by character position.
module message_rom
  import uart_message_printer_pkg::*;
(
  input  logic [3:0] i_addr,
  input  logic [7:0] i_byte,
  output logic [7:0] o_char
);

  always_comb begin
    o_char = 8'h00;
    case (i_addr)
      4'd0:    o_char = 8'h47;  // G
      4'd1:    o_char = 8'h6F;  // o
      4'd2:    o_char = 8'h74;  // t
      4'd3:    o_char = 8'h20;
      4'd4:    o_char = 8'h62;  // b
      4'd5:    o_char = 8'h79;  // y
      4'd6:    o_char = 8'h74;  // t
      4'd7:    o_char = 8'h65;  // e
      4'd8:    o_char = 8'h20;
      4'd9:    o_char = 8'h30;  // 0
      4'd10:   o_char = 8'h78;  // x
      4'd11:   o_char = hex_to_ascii(i_byte[7:4]);
      4'd12:   o_char = hex_to_ascii(i_byte[3:0]);
      4'd13:   o_char = CR;
      4'd14:   o_char = LF;
      default: o_char = 8'h00;
    endcase
  end

endmodule

// File: rtl/uart_message_printer.sv
// Collects eight '0'/'1' characters MSB-first into a byte, then sends
// "Got byte 0xHH\r\n" one character per tx handshake.
module uart_message_printer #(
  parameter int unsigned MSG_LEN = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  output logic [3:0] addr
);
  import uart_message_printer_pkg::*;

  localparam logic [3:0] LAST_ADDR = 4'(MSG_LEN - 1);

  state_t     r_state, w_state_next;
  logic       r_rx_prev;
  logic [2:0] r_bit_cnt, w_bit_cnt_next;
  logic [7:0] r_shift, w_shift_next;
  logic [7:0] r_byte, w_byte_next;
  logic [7:0] r_tx_data, w_tx_data_next;
  logic       r_new_tx, w_new_tx_next;
  logic [3:0] r_addr, w_addr_next;
  logic       w_rx_evt;
  logic       w_rx_bit_ok;
  logic [7:0] w_rom_char;

  // A strobe held for several cycles still yields a single receive event.
  assign w_rx_evt    = new_rx_data & ~r_rx_prev;
  assign w_rx_bit_ok = (rx_data == ASCII_0) || (rx_data == ASCII_1);

  assign tx_data     = r_tx_data;
  assign new_tx_data = r_new_tx;
  assign addr        = r_addr;

  message_rom u_message_rom (
    .i_addr (r_addr),
    .i_byte (r_byte),
    .o_char (w_rom_char)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= COLLECT;
      r_rx_prev <= 1'b0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_byte    <= 8'h00;
      r_tx_data <= 8'h00;
      r_new_tx  <= 1'b0;
      r_addr    <= 4'd0;
    end else begin
      r_state   <= w_state_next;
      r_rx_prev <= new_rx_data;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
      r_byte    <= w_byte_next;
      r_tx_data <= w_tx_data_next;
      r_new_tx  <= w_new_tx_next;
      r_addr    <= w_addr_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_byte_next    = r_byte;
    w_tx_data_next = r_tx_data;
    w_new_tx_next  = 1'b0;
    w_addr_next    = r_addr;
    case (r_state)
      COLLECT: begin
        if (w_rx_evt && w_rx_bit_ok) begin
          w_shift_next = {r_shift[6:0], rx_data[0]};
          if (r_bit_cnt == 3'd7) begin
            w_byte_next    = {r_shift[6:0], rx_data[0]};
            w_bit_cnt_next = 3'd0;
            w_addr_next    = 4'd0;
            w_state_next   = PRINT;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end
        end
      end
      PRINT: begin
        // Skipping the cycle after a request gives tx_busy time to rise.
        if (!tx_busy && !r_new_tx) begin
          w_new_tx_next  = 1'b1;
          w_tx_data_next = w_rom_char;
          if (r_addr == LAST_ADDR) begin
            w_addr_next  = 4'd0;
            w_state_next = COLLECT;
          end else begin
            w_addr_next = r_addr + 4'd1;
          end
        end
      end
      default: w_state_next = COLLECT;
    endcase
  end

endmodule

// File: tb/tb_uart_message_printer.sv
// Directed bench for uart_message_printer: feeds binary-digit strobes and checks
// every transmitted character, its addr, pulse spacing and busy handling.
module tb_uart_message_printer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       new_rx_data = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic [3:0] addr;

  uart_message_printer #(.MSG_LEN(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .addr        (addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] got_q[$];
  logic [3:0] addr_q[$];
  int         cyc_q[$];
  bit         busy_mode = 1'b0;
  int         busy_cnt = 0;
  bit         prev_pulse = 1'b0;
  int         last_drive = 0;

  // Capture each pulse; optionally model a transmitter busy for 20 cycles.
  always @(negedge clk) begin
    if (new_tx_data === 1'b1) begin
      check("busy_gap", {31'd0, tx_busy}, 32'd0);
      check("spacing", {31'd0, prev_pulse}, 32'd0);
      got_q.push_back(tx_data);
      addr_q.push_back(addr);
      cyc_q.push_back(cyc);
      if (busy_mode) busy_cnt = 20;
    end
    prev_pulse = (new_tx_data === 1'b1);
    if (busy_cnt > 0) begin
      tx_busy = 1'b1;
      busy_cnt--;
    end else begin
      tx_busy = 1'b0;
    end
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [7:0] exp_char(input logic [7:0] b, input int i);
    string s;
    s = "Got byte 0x";
    if (i < 11) return s[i];
    if (i == 11) return hexc(b[7:4]);
    if (i == 12) return hexc(b[3:0]);
    if (i == 13) return 8'h0D;
    return 8'h0A;
  endfunction

  task automatic clear_q();
    got_q.delete();
    addr_q.delete();
    cyc_q.delete();
  endtask

  task automatic send_char(input logic [7:0] c, input int hold);
    @(posedge clk); #1;
    rx_data     = c;
    new_rx_data = 1'b1;
    last_drive  = cyc;
    repeat (hold) @(posedge clk);
    #1;
    new_rx_data = 1'b0;
    rx_data     = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    for (int i = 7; i >= 0; i--) send_char(b[i] ? 8'h31 : 8'h30, hold);
  endtask

  task automatic expect_msg(input string tag, input logic [7:0] b, input int t0, input bit chk_time);
    int waited;
    int n;
    logic [7:0] c;
    logic [3:0] a;
    waited = 0;
    while (got_q.size() < 15 && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    @(negedge clk); #1;
    check({tag, "_count"}, got_q.size(), 32'd15);
    if (chk_time && cyc_q.size() >= 15) begin
      check({tag, "_latency"}, cyc_q[0] - t0, 32'd2);
      check({tag, "_duration"}, cyc_q[14] - cyc_q[0], 32'd28);
    end
    n = got_q.size();
    for (int i = 0; i < 15 && i < n; i++) begin
      c = got_q.pop_front();
      a = addr_q.pop_front();
      check($sformatf("%s_char%0d", tag, i), {24'd0, c}, {24'd0, exp_char(b, i)});
      check($sformatf("%s_addr%0d", tag, i), {28'd0, a}, (i + 1) % 15);
    end
    repeat (20) @(posedge clk);
    #1;
    check({tag, "_idle"}, got_q.size(), 32'd0);
    clear_q();
    $display("msg %s byte=0x%02h checked", tag, b);
  endtask

  initial begin
    int t0;
    int waited;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_new_tx", {31'd0, new_tx_data}, 32'd0);
    check("rst_addr", {28'd0, addr}, 32'd0);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rst_no_activity", got_q.size(), 32'd0);
    check("rst_addr_idle", {28'd0, addr}, 32'd0);

    // 0xF0 with strobes of 2 and 3 cycles
    b = 8'hF0;
    for (int i = 7; i >= 0; i--) send_char(b[i] ? 8'h31 : 8'h30, 2 + (i % 2));
    t0 = last_drive;
    expect_msg("f0", 8'hF0, t0, 1'b1);

    // first bit held high for 10 cycles must count once
    send_char(8'h31, 10);
    b = 8'hA5;
    for (int i = 6; i >= 0; i--) send_char(b[i] ? 8'h31 : 8'h30, 2);
    t0 = last_drive;
    expect_msg("long", 8'hA5, t0, 1'b1);

    // non-digit characters interleaved
    b = 8'h5A;
    for (int i = 7; i >= 0; i--) begin
      send_char((i % 2) ? 8'h78 : 8'h32, 2);
      send_char(b[i] ? 8'h31 : 8'h30, 2);
    end
    t0 = last_drive;
    expect_msg("junk", 8'h5A, t0, 1'b1);

    // transmitter busy 20 cycles after every request
    busy_mode = 1'b1;
    send_byte(8'h3C, 2);
    expect_msg("busy", 8'h3C, 0, 1'b0);
    busy_mode = 1'b0;
    repeat (25) @(posedge clk);

    // extra strobes during PRINT, then a fresh byte
    send_byte(8'h96, 2);
    t0 = last_drive;
    repeat (3) send_char(8'h31, 2);
    expect_msg("extra", 8'h96, t0, 1'b1);
    send_byte(8'h81, 2);
    t0 = last_drive;
    expect_msg("fresh", 8'h81, t0, 1'b1);

    // reset in the middle of a message
    send_byte(8'hC3, 2);
    waited = 0;
    @(negedge clk);
    while (addr !== 4'd6 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("reach_addr6", {28'd0, addr}, 32'd6);
    rst = 1'b0;
    #1;
    check("midrst_tx_data", {24'd0, tx_data}, 32'd0);
    check("midrst_new_tx", {31'd0, new_tx_data}, 32'd0);
    check("midrst_addr", {28'd0, addr}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_q();
    repeat (30) @(posedge clk);
    #1;
    check("midrst_no_resume", got_q.size(), 32'd0);
    send_byte(8'h7E, 2);
    t0 = last_drive;
    expect_msg("after_rst", 8'h7E, t0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_message_printer.md
# uart_message_printer

Collects eight ASCII binary digits ('0'/'1') from a UART receiver, assembles them MSB-first into one byte, then prints the fixed 15-character message "Got byte 0xHH\r\n" through a UART transmitter. HH is the byte in uppercase hex. The block sits between the UART rx/tx cores and is the top-level "echo" function of the serial test design. The module name is uart_message_printer.

## Interface
Parameters:
- MSG_LEN, 15: characters per printed message; fixed, not overridable in practice.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx_data  input  8  received character, valid while new_rx_data is high.
- new_rx_data  input  1  receiver strobe; may be held high for several cycles, counts once per rising edge.
- tx_busy  input  1  transmitter busy; rises by the cycle after new_tx_data.
- tx_data  output  8  character to transmit, registered.
- new_tx_data  output  1  one-cycle transmit request, registered.
- addr  output  4  index (0..14) of the message character currently being sent, registered.

## Operation
- The block uses one clock; reset is asynchronous and active-low.
- Reset values:
  - tx_data = 8'h00, new_tx_data = 0, addr = 0.
  - Bit counter = 0, shift register = 0, state = COLLECT.
  - Registered copy of new_rx_data = 0.
- Receive event: new_rx_data = 1 this cycle and 0 in the previous sampled cycle. rx_data is sampled in that cycle.
- COLLECT state:
  - Event with rx_data = 8'h30 ('0') or 8'h31 ('1'): shift reg = {shift[6:0], rx_data[0]} and bit count += 1.
  - Any other character is ignored; it changes neither the counter nor the shift register.
  - On the 8th valid bit, latch the byte, clear the bit count, set addr = 0, and go to PRINT.
- PRINT state:
  - If tx_busy = 0 and new_tx_data was 0 in the previous cycle, assert new_tx_data for one cycle with tx_data = msg[addr].
  - After each issue, increment addr. Issuing the character at addr = 14 returns the block to COLLECT with addr = 0.
- Message:
  - addr 0..10 = "Got byte 0x".
  - addr 11 = hex of the high nibble; addr 12 = hex of the low nibble. Digits are '0'-'9' and 'A'-'F'.
  - addr 13 = 8'h0D, addr 14 = 8'h0A.
- Receive events during PRINT are ignored and do not advance the bit counter.
- Reset asserted mid-print aborts immediately to the reset values. The partial message is not resumed.

## Timing
- new_rx_data is registered for edge detect. A strobe lasting N ≥ 1 cycles yields exactly one bit. The next bit needs new_rx_data to return low for at least one cycle.
- From the 8th receive event at cycle T:
  - State is PRINT at T+1.
  - The first new_tx_data pulse is at T+2 if tx_busy is low.
- Minimum spacing between transmit requests is 2 cycles. The guard cycle covers the one-cycle tx_busy rise latency.
- If tx_busy stays high, hold the current addr and tx_data. new_tx_data stays 0.
- A full message with tx_busy always low takes 30 cycles: 15 pulses, every other cycle.

## Structure
- Shared package:
  - State enum {COLLECT, PRINT}.
  - MSG_LEN = 15, ASCII_0 = 8'h30, ASCII_1 = 8'h31, CR = 8'h0D, LF = 8'h0A.
  - Hex-to-ASCII function.
- One natural sub-module, message_rom: combinational; inputs addr[3:0] and byte[7:0]; output char[7:0]. Unused addresses 15 return 8'h00.
- The top level holds the edge detect, collector, FSM and tx handshake.

## Test plan
- Reset: hold rst low, then release → tx_data = 0, new_tx_data = 0, addr = 0. No activity without rx.
- Send '1','1','1','1','0','0','0','0' with strobes of 2–3 cycles; tx_busy = 0 → 15 single-cycle pulses spelling "Got byte 0xF0\r\n" at addr 0..14, then idle.
- Single strobe held high 10 cycles → counts as one bit only. Interleave 'x' characters in an 8-bit sequence → ignored; the byte is still correct (e.g. 0x5A → "...0x5A").
- Model tx_busy high for 20 cycles after each request → each character is sent exactly once, in order, with no pulse while busy.
- Send 8 bits, then 3 extra '1' strobes during PRINT → message unchanged. After the message, the bit counter is 0 and the next 8 bits form a fresh byte.
- Assert rst at addr = 6 mid-print → outputs go to their reset values at once. The next 8 bits print a complete new message.
